// File: rtl/zion_riscv_isa_lib_sft_decode_if.sv
// -----------------------------------------------------------------------------
// zion_riscv_isa_lib_sft_decode_if
// Shift-execution bundle passed from the decode/issue stage to the shift unit.
//   RV64 = 0 : op[2:0], s1[31:0], s2[4:0]
//   RV64 = 1 : op[3:0], s1[63:0], s2[5:0]
// op bits: [0] left, [1] right, [2] arithmetic, [3] W (RV64 only).
// Modports:
//   De : decode side, drives op/s1/s2
//   Ex : execute side, reads op/s1/s2
// -----------------------------------------------------------------------------
interface zion_riscv_isa_lib_sft_decode_if #(
  parameter int RV64 = 0
);
  localparam int CPU_WIDTH = (RV64 != 0) ? 64 : 32;
  localparam int OP_W      = (RV64 != 0) ? 4 : 3;
  localparam int S2_W      = (RV64 != 0) ? 6 : 5;

  logic [OP_W-1:0]      op;
  logic [CPU_WIDTH-1:0] s1;
  logic [S2_W-1:0]      s2;

  modport De (output op, output s1, output s2);
  modport Ex (input op, input s1, input s2);
endinterface

// File: rtl/zion_riscv_isa_lib_sft_decode.sv
// -----------------------------------------------------------------------------
// zion_riscv_isa_lib_sft_decode
// Decode-side issue stage for the shift execution unit. Recognises the RV32I
// (or RV64I when RV64=1) shift instructions, builds the op/s1/s2 bundle and
// presents it through a two-entry skid buffer (main + skid) so that the
// upstream ready is a registered term.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   iFlush       synchronous flush, clears both buffered entries
//   iVld/oRdy    upstream handshake (instruction in)
//   iInstr       32-bit instruction word
//   iRs1/iRs2    operand values (CPU_WIDTH bits)
//   oVld/iRdy    downstream handshake (bundle out)
//   oSftExIf     shift-execution interface, De modport (op, s1, s2)
//   oIllegal     qualifies oVld: beat is a malformed shift encoding
//
// Configuration macro: ZION_RISCV_SFT_DECODE_ILLEGAL_EN
//   defined   : malformed funct7 / high-immediate encodings raise oIllegal
//   undefined : oIllegal is 0; decode looks at opcode, funct3, instr[30] only
// -----------------------------------------------------------------------------
module zion_riscv_isa_lib_sft_decode #(
  parameter int RV64 = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                iFlush,
  input  logic                                iVld,
  output logic                                oRdy,
  input  logic [31:0]                         iInstr,
  input  logic [((RV64 != 0) ? 64 : 32)-1:0]  iRs1,
  input  logic [((RV64 != 0) ? 64 : 32)-1:0]  iRs2,
  output logic                                oVld,
  input  logic                                iRdy,
  zion_riscv_isa_lib_sft_decode_if.De         oSftExIf,
  output logic                                oIllegal
);

  localparam int CPU_WIDTH = (RV64 != 0) ? 64 : 32;
  localparam int OP_W      = (RV64 != 0) ? 4 : 3;
  localparam int S2_W      = (RV64 != 0) ? 6 : 5;
  localparam bit IS_RV64   = (RV64 != 0);

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef struct packed {
    logic                 ill;
    logic [OP_W-1:0]      op;
    logic [CPU_WIDTH-1:0] s1;
    logic [S2_W-1:0]      s2;
  } entry_t;

  // Decode intermediates
  logic       is_imm_s;
  logic       is_reg_s;
  logic       is_w_s;
  logic       is_left_s;
  logic       is_sft_s;
  logic       hi_bad_s;
  logic [3:0] full_op_s;
  logic [5:0] full_s2_s;
  entry_t     dec_s;

  // Buffer state
  logic   main_vld_r, main_vld_n_s;
  logic   skid_vld_r, skid_vld_n_s;
  logic   rdy_r;
  entry_t main_r, main_n_s;
  entry_t skid_r, skid_n_s;
  logic   accept_s;

  // Operand bits the decoder never inspects (register indices, upper rs2).
  logic unused_s;
  assign unused_s = ^{iInstr[31:26], iInstr[19:15], iInstr[11:7], iRs2};

  // Instruction decode into a candidate buffer entry
  always_comb begin
    dec_s     = '0;
    hi_bad_s  = 1'b0;
    full_s2_s = 6'd0;

    is_imm_s  = (iInstr[6:0] == OPC_OP_IMM) ||
                (IS_RV64 && (iInstr[6:0] == OPC_OP_IMM_32));
    is_reg_s  = (iInstr[6:0] == OPC_OP) ||
                (IS_RV64 && (iInstr[6:0] == OPC_OP_32));
    is_w_s    = IS_RV64 && ((iInstr[6:0] == OPC_OP_IMM_32) ||
                            (iInstr[6:0] == OPC_OP_32));
    is_left_s = (iInstr[14:12] == 3'b001);
    is_sft_s  = (is_imm_s || is_reg_s) &&
                (is_left_s || (iInstr[14:12] == 3'b101));

    // instr[30] selects arithmetic only for right shifts
    full_op_s = {is_w_s, (!is_left_s) & iInstr[30], !is_left_s, is_left_s};

    if (is_imm_s) begin
      // Only RV64 non-W immediates own a 6-bit shamt
      if (IS_RV64 && !is_w_s) begin
        full_s2_s = iInstr[25:20];
      end else begin
        full_s2_s = {1'b0, iInstr[24:20]};
      end
    end else begin
      // W register forms shift by at most 31
      if (is_w_s) begin
        full_s2_s = {1'b0, iRs2[4:0]};
      end else begin
        full_s2_s = iRs2[5:0];
      end
    end

`ifdef ZION_RISCV_SFT_DECODE_ILLEGAL_EN
    // Bit 30 is the only legal non-zero high bit; bit 25 is also legal
    // when it is shamt[5] of an RV64 non-W immediate.
    hi_bad_s = iInstr[31] | (|iInstr[29:26]) |
               (iInstr[25] & !(is_imm_s && IS_RV64 && !is_w_s)) |
               (is_left_s & iInstr[30]);
`else
    hi_bad_s = 1'b0;
`endif

    if (is_sft_s) begin
      if (hi_bad_s) begin
        dec_s.ill = 1'b1;
      end else begin
        dec_s.op = full_op_s[OP_W-1:0];
        dec_s.s1 = iRs1;
        dec_s.s2 = full_s2_s[S2_W-1:0];
      end
    end else begin
      dec_s = '0;
    end
  end

  assign accept_s = iVld & rdy_r;

  // Skid-buffer next state: main feeds the outputs, skid catches the beat
  // accepted while main is stalled. Accept implies skid is empty.
  always_comb begin
    main_vld_n_s = main_vld_r;
    skid_vld_n_s = skid_vld_r;
    main_n_s     = main_r;
    skid_n_s     = skid_r;
    if (iFlush) begin
      main_vld_n_s = 1'b0;
      skid_vld_n_s = 1'b0;
      main_n_s     = '0;
      skid_n_s     = '0;
    end else if (!main_vld_r || iRdy) begin
      if (skid_vld_r) begin
        main_vld_n_s = 1'b1;
        main_n_s     = skid_r;
        skid_vld_n_s = 1'b0;
      end else if (accept_s) begin
        main_vld_n_s = 1'b1;
        main_n_s     = dec_s;
      end else begin
        main_vld_n_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_vld_n_s = 1'b1;
        skid_n_s     = dec_s;
      end else begin
        skid_vld_n_s = skid_vld_r;
      end
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_r <= 1'b0;
      skid_vld_r <= 1'b0;
      rdy_r      <= 1'b1;
      main_r     <= '0;
      skid_r     <= '0;
    end else begin
      main_vld_r <= main_vld_n_s;
      skid_vld_r <= skid_vld_n_s;
      rdy_r      <= !skid_vld_n_s;
      main_r     <= main_n_s;
      skid_r     <= skid_n_s;
    end
  end

  assign oRdy        = rdy_r;
  assign oVld        = main_vld_r;
  assign oIllegal    = main_r.ill;
  assign oSftExIf.op = main_r.op;
  assign oSftExIf.s1 = main_r.s1;
  assign oSftExIf.s2 = main_r.s2;

endmodule

// File: tb/tb_zion_riscv_isa_lib_sft_decode.sv
// -----------------------------------------------------------------------------
// tb_zion_riscv_isa_lib_sft_decode
// Directed bench driving an RV32 and an RV64 instance with shared stimulus.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_zion_riscv_isa_lib_sft_decode;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        vld;
  logic        rdy;
  logic [31:0] instr;
  logic [63:0] rs1;
  logic [63:0] rs2;

  logic rdy32, vld32, ill32;
  logic rdy64, vld64, ill64;

  int tests_run;
  int tests_failed;

  zion_riscv_isa_lib_sft_decode_if #(.RV64(0)) if32 ();
  zion_riscv_isa_lib_sft_decode_if #(.RV64(1)) if64 ();

  zion_riscv_isa_lib_sft_decode #(.RV64(0)) u_dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .iFlush   (flush),
    .iVld     (vld),
    .oRdy     (rdy32),
    .iInstr   (instr),
    .iRs1     (rs1[31:0]),
    .iRs2     (rs2[31:0]),
    .oVld     (vld32),
    .iRdy     (rdy),
    .oSftExIf (if32),
    .oIllegal (ill32)
  );

  zion_riscv_isa_lib_sft_decode #(.RV64(1)) u_dut64 (
    .clk      (clk),
    .rst_n    (rst_n),
    .iFlush   (flush),
    .iVld     (vld),
    .oRdy     (rdy64),
    .iInstr   (instr),
    .iRs1     (rs1),
    .iRs2     (rs2),
    .oVld     (vld64),
    .iRdy     (rdy),
    .oSftExIf (if64),
    .oIllegal (ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic v, input logic [2:0] op,
                       input logic [31:0] s1, input logic [4:0] s2, input logic il);
    check({tag, "/vld32"}, {63'd0, vld32}, {63'd0, v});
    check({tag, "/op32"},  {61'd0, if32.op}, {61'd0, op});
    check({tag, "/s1_32"}, {32'd0, if32.s1}, {32'd0, s1});
    check({tag, "/s2_32"}, {59'd0, if32.s2}, {59'd0, s2});
    check({tag, "/ill32"}, {63'd0, ill32}, {63'd0, il});
  endtask

  task automatic chk64(input string tag, input logic v, input logic [3:0] op,
                       input logic [63:0] s1, input logic [5:0] s2, input logic il);
    check({tag, "/vld64"}, {63'd0, vld64}, {63'd0, v});
    check({tag, "/op64"},  {60'd0, if64.op}, {60'd0, op});
    check({tag, "/s1_64"}, if64.s1, s1);
    check({tag, "/s2_64"}, {58'd0, if64.s2}, {58'd0, s2});
    check({tag, "/ill64"}, {63'd0, ill64}, {63'd0, il});
  endtask

  localparam logic [31:0] I_SLLI3   = 32'h0030_9093;
  localparam logic [31:0] I_SRAW    = 32'h4020_D0BB;
  localparam logic [31:0] I_SRLI33  = 32'h0210_D093;
  localparam logic [31:0] I_SRA     = 32'h4020_D0B3;
  localparam logic [31:0] I_SLLI_30 = 32'h4030_9093;
  localparam logic [31:0] I_ADD     = 32'h0031_00B3;
  localparam logic [31:0] I_A       = 32'h0010_9093;
  localparam logic [31:0] I_B       = 32'h0020_9093;
  localparam logic [31:0] I_C       = 32'h0050_9093;
  localparam logic [63:0] RS1_W     = 64'h1234_5678_9ABC_DEF0;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    vld   = 1'b0;
    rdy   = 1'b0;
    instr = 32'd0;
    rs1   = 64'd0;
    rs2   = 64'd0;

    // Reset values
    repeat (2) @(negedge clk);
    chk32("reset", 1'b0, 3'd0, 32'd0, 5'd0, 1'b0);
    chk64("reset", 1'b0, 4'd0, 64'd0, 6'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_reset32", {63'd0, rdy32}, 64'd1);
    check("rdy_after_reset64", {63'd0, rdy64}, 64'd1);

    // Back-to-back decode vectors, sustained vld=rdy=1
    rdy = 1'b1;
    vld = 1'b1;
    instr = I_SLLI3;
    rs1 = 64'h0000_0000_8000_0001;
    rs2 = 64'd0;
    @(negedge clk);
    chk32("slli3", 1'b1, 3'b001, 32'h8000_0001, 5'd3, 1'b0);
    chk64("slli3", 1'b1, 4'b0001, 64'h0000_0000_8000_0001, 6'd3, 1'b0);

    instr = I_SRAW;
    rs1 = RS1_W;
    rs2 = 64'h3F;
    @(negedge clk);
    chk32("sraw", 1'b1, 3'd0, 32'd0, 5'd0, 1'b0);
    chk64("sraw", 1'b1, 4'b1110, RS1_W, 6'd31, 1'b0);

    instr = I_SRLI33;
    @(negedge clk);
`ifdef ZION_RISCV_SFT_DECODE_ILLEGAL_EN
    chk32("srli33", 1'b1, 3'd0, 32'd0, 5'd0, 1'b1);
`else
    chk32("srli33", 1'b1, 3'b010, 32'h9ABC_DEF0, 5'd1, 1'b0);
`endif
    chk64("srli33", 1'b1, 4'b0010, RS1_W, 6'd33, 1'b0);

    instr = I_SRA;
    @(negedge clk);
    chk32("sra", 1'b1, 3'b110, 32'h9ABC_DEF0, 5'd31, 1'b0);
    chk64("sra", 1'b1, 4'b0110, RS1_W, 6'd63, 1'b0);

    instr = I_SLLI_30;
    @(negedge clk);
`ifdef ZION_RISCV_SFT_DECODE_ILLEGAL_EN
    chk32("slli_b30", 1'b1, 3'd0, 32'd0, 5'd0, 1'b1);
    chk64("slli_b30", 1'b1, 4'd0, 64'd0, 6'd0, 1'b1);
`else
    chk32("slli_b30", 1'b1, 3'b001, 32'h9ABC_DEF0, 5'd3, 1'b0);
    chk64("slli_b30", 1'b1, 4'b0001, RS1_W, 6'd3, 1'b0);
`endif

    instr = I_ADD;
    @(negedge clk);
    chk32("add", 1'b1, 3'd0, 32'd0, 5'd0, 1'b0);
    chk64("add", 1'b1, 4'd0, 64'd0, 6'd0, 1'b0);

    vld = 1'b0;
    @(negedge clk);
    check("idle_vld32", {63'd0, vld32}, 64'd0);

    // Skid: iRdy=0 for four cycles, A/B/C offered back to back
    rdy = 1'b0;
    vld = 1'b1;
    instr = I_A;
    @(negedge clk);
    check("skid_a_vld", {63'd0, vld32}, 64'd1);
    check("skid_a_s2", {59'd0, if32.s2}, 64'd1);
    check("skid_a_rdy", {63'd0, rdy32}, 64'd1);
    instr = I_B;
    @(negedge clk);
    check("skid_hold1_s2", {59'd0, if32.s2}, 64'd1);
    check("skid_full_rdy", {63'd0, rdy32}, 64'd0);
    check("skid_full_rdy64", {63'd0, rdy64}, 64'd0);
    instr = I_C;
    @(negedge clk);
    check("skid_hold2_s2", {59'd0, if32.s2}, 64'd1);
    check("skid_c_blocked", {63'd0, rdy32}, 64'd0);
    @(negedge clk);
    check("skid_hold3_s2", {59'd0, if32.s2}, 64'd1);
    check("skid_hold3_vld", {63'd0, vld32}, 64'd1);
    rdy = 1'b1;
    @(negedge clk);
    check("skid_b_s2", {59'd0, if32.s2}, 64'd2);
    check("skid_b_vld", {63'd0, vld32}, 64'd1);
    check("skid_rdy_back", {63'd0, rdy32}, 64'd1);
    @(negedge clk);
    check("skid_c_s2", {59'd0, if32.s2}, 64'd5);
    check("skid_c_vld", {63'd0, vld32}, 64'd1);
    check("skid_c_s2_64", {58'd0, if64.s2}, 64'd5);
    vld = 1'b0;
    @(negedge clk);
    check("skid_drained", {63'd0, vld32}, 64'd0);

    // Flush with both entries full and iVld=1
    rdy = 1'b0;
    vld = 1'b1;
    instr = I_A;
    @(negedge clk);
    instr = I_B;
    @(negedge clk);
    check("flush_pre_rdy", {63'd0, rdy32}, 64'd0);
    check("flush_pre_vld", {63'd0, vld32}, 64'd1);
    flush = 1'b1;
    instr = I_C;
    @(negedge clk);
    check("flush_vld32", {63'd0, vld32}, 64'd0);
    check("flush_vld64", {63'd0, vld64}, 64'd0);
    check("flush_rdy32", {63'd0, rdy32}, 64'd1);
    // Flush together with an accepted beat: the beat is discarded
    @(negedge clk);
    check("flush_accept_vld", {63'd0, vld32}, 64'd0);
    flush = 1'b0;
    vld = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    check("flush_no_ghost32", {63'd0, vld32}, 64'd0);
    check("flush_no_ghost64", {63'd0, vld64}, 64'd0);

    // Asynchronous reset while a beat is presented
    rdy = 1'b0;
    vld = 1'b1;
    instr = I_SLLI3;
    rs1 = RS1_W;
    @(negedge clk);
    vld = 1'b0;
    check("pre_rst_vld", {63'd0, vld32}, 64'd1);
    check("pre_rst_op", {61'd0, if32.op}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vld32", {63'd0, vld32}, 64'd0);
    check("async_rst_vld64", {63'd0, vld64}, 64'd0);
    check("async_rst_op32", {61'd0, if32.op}, 64'd0);
    check("async_rst_s1_64", if64.s1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
